// File: rtl/pu_riscv_pkg.sv
// Shared types and decode constants for the RISC-V execute-stage sequencer.
package pu_riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } ex_seq_state_t;

   localparam logic [4:0] OPC_OP        = 5'b01100;
   localparam logic [4:0] OPC_OP32      = 5'b01110;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/pu_riscv_ex_seq.sv
// Execute-stage sequencer: arbitrates the EX->WB result path between the
// single-cycle ALU and a multi-cycle MUL/DIV unit, with flush and watchdog abort.
module pu_riscv_ex_seq
   import pu_riscv_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int ILEN       = 64,
   parameter int MD_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_bubble,
   input  logic [ILEN-1:0] id_instr,
   input  logic            ex_flush,
   input  logic            wb_stall,
   input  logic            alu_bubble,
   input  logic [XLEN-1:0] alu_r,
   output logic            md_req,
   input  logic            md_ack,
   input  logic            md_valid,
   input  logic [XLEN-1:0] md_r,
   output logic            md_abort,
   output logic            ex_stall,
   output logic            ex_bubble,
   output logic [XLEN-1:0] ex_r,
   output logic            ex_timeout
);

   localparam int            CW       = $clog2(MD_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

   ex_seq_state_t   state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            timeout_q, timeout_d;
   logic            is_md, issue;
   logic            unused_instr;

   // Only opcode and funct7 matter; the rest of the instruction is decoded elsewhere.
   assign unused_instr = ^id_instr;

   assign is_md = ~id_bubble
                & ((id_instr[6:2] == OPC_OP) | (id_instr[6:2] == OPC_OP32))
                & (id_instr[31:25] == FUNCT7_MULDIV);
   assign issue = is_md & ~ex_flush & (state_q == IDLE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      timeout_d = timeout_q;
      md_req    = 1'b0;
      md_abort  = 1'b0;
      ex_stall  = 1'b1;
      ex_bubble = 1'b1;
      ex_r      = '0;

      case (state_q)
         IDLE: begin
            ex_r      = alu_r;
            ex_bubble = alu_bubble;
            md_req    = issue;
            ex_stall  = issue | wb_stall;
            if (issue) begin
               cnt_d   = '0;
               state_d = md_ack ? WAIT : REQ;
            end
         end
         REQ: begin
            md_req = 1'b1;
            // A flush racing an accept still has to cancel the unit.
            if (ex_flush) begin
               md_abort = md_ack;
               state_d  = IDLE;
            end else if (md_ack) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (ex_flush) begin
               md_abort = 1'b1;
               state_d  = IDLE;
            end else if (md_valid) begin
               res_d   = md_r;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               md_abort  = 1'b1;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         DONE: begin
            ex_r      = res_q;
            ex_bubble = ex_flush;
            ex_stall  = wb_stall;
            if (ex_flush | ~wb_stall)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         md_req    = 1'b0;
         md_abort  = 1'b0;
         ex_stall  = 1'b0;
         ex_bubble = alu_bubble;
         ex_r      = alu_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         res_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         timeout_q <= timeout_d;
      end
   end

   assign ex_timeout = timeout_q;

endmodule

// File: doc/pu_riscv_ex_seq.md
Name: pu_riscv_ex_seq

Overview:
Execute-stage sequencer that shares the execute-to-writeback result path between the single-cycle ALU and an external multi-cycle MUL/DIV unit.
- Decodes M-extension ops from the ID instruction and drives the MUL/DIV request/ack handshake.
- Stalls the pipeline while a MUL/DIV op is outstanding and muxes the final result and bubble flag to WB.
- Handles flush (branch/exception) abort and a watchdog timeout.

Parameters:
XLEN, 64, datapath width
ILEN, 64, instruction bus width
MD_TIMEOUT, 64, max cycles in WAIT before forced abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_bubble  in  1  ID-stage instruction is a bubble
id_instr  in  ILEN  ID-stage instruction
ex_flush  in  1  kill the in-flight instruction
wb_stall  in  1  WB cannot accept a result this cycle
alu_bubble  in  1  ALU result-valid complement (registered in ALU)
alu_r  in  XLEN  ALU result
md_req  out  1  MUL/DIV operation request
md_ack  in  1  MUL/DIV accepted the request
md_valid  in  1  MUL/DIV result valid (1-cycle pulse)
md_r  in  XLEN  MUL/DIV result
md_abort  out  1  cancel the accepted MUL/DIV op (1-cycle pulse)
ex_stall  out  1  freeze ID/EX
ex_bubble  out  1  result to WB is a bubble
ex_r  out  XLEN  result to WB
ex_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset is synchronous, active-high, one clock:
  - Registers: state=IDLE, cnt=0, res=0, ex_timeout=0.
  - Outputs while in reset: md_req=0, md_abort=0, ex_stall=0, ex_bubble=alu_bubble, ex_r=alu_r.
- is_md: all of the following hold:
  - id_instr[6:2] is 5'b01100 (OP) or 5'b01110 (OP-32).
  - id_instr[31:25]=7'b0000001.
  - id_bubble=0.
- issue: is_md & ~ex_flush & state==IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ex_r=alu_r, ex_bubble=alu_bubble.
  - On issue: md_req=1 combinationally. md_ack=1 -> WAIT; otherwise -> REQ.
  - ex_stall = issue | wb_stall.
- REQ:
  - md_req=1, ex_stall=1, ex_bubble=1, ex_r=0.
  - md_ack -> WAIT.
  - ex_flush -> IDLE, no abort (op was never accepted). Flush has priority over md_ack in the same cycle; md_abort pulses if md_ack coincides.
- WAIT:
  - md_req=0, ex_stall=1, ex_bubble=1, ex_r=0.
  - cnt increments each cycle; cnt clears on entering WAIT.
  - Priority order:
    1. ex_flush -> md_abort=1 for 1 cycle, -> IDLE, result discarded.
    2. md_valid -> res<=md_r, -> DONE.
    3. cnt==MD_TIMEOUT-1 -> md_abort=1, ex_timeout<=1, -> IDLE. The instruction is dropped as a bubble.
- DONE:
  - ex_r=res, ex_bubble=0, ex_stall=wb_stall.
  - ~wb_stall -> IDLE. The next ID instruction advances this same cycle.
  - ex_flush -> IDLE with ex_bubble forced to 1.
- Latency:
  - MUL/DIV result appears at ex_r 1 cycle after md_valid.
  - ALU results pass through with 0 added latency.
- ex_timeout clears only on rst.
- md_valid outside WAIT is ignored.
- Reset mid-op: returns to IDLE with no md_abort. The MUL/DIV unit shares rst.

Decomposition:
- pu_riscv_pkg:
  - ex_seq_state_t enum (IDLE, REQ, WAIT, DONE).
  - Opcode constants OPC_OP=5'b01100, OPC_OP32=5'b01110.
  - FUNCT7_MULDIV=7'b0000001.
- Single module; no sub-module is warranted (decode is 3 compares).

Test Plan:
- ADD (is_md=0), alu_r=0x5, alu_bubble=0 -> ex_r=0x5, ex_bubble=0, ex_stall=0, md_req never 1.
- MUL with md_ack same cycle, md_valid 3 cycles later with md_r=0x2A -> ex_stall high for 4 cycles, ex_r=0x2A with ex_bubble=0 for 1 cycle, then IDLE.
- DIV with md_ack delayed 2 cycles -> md_req high for 3 cycles, state REQ->WAIT, result delivered after md_valid.
- ex_flush during WAIT -> md_abort single-cycle pulse, no result to WB (ex_bubble=1), ex_stall drops the next cycle; a later md_valid is ignored.
- md_valid never arrives, MD_TIMEOUT=8 -> md_abort on the 8th WAIT cycle, ex_timeout=1 and held until rst.
- wb_stall=1 for 2 cycles in DONE with res=0x7 -> ex_r=0x7 and ex_stall=1 held for 2 cycles, then IDLE. rst asserted in WAIT -> all outputs at reset values next cycle.
